// File: rtl/led_peak_hold.sv
// led_peak_hold
//   Drives the LED bar from the software-written pattern and adds a dimmed
//   peak-hold marker. The highest level seen stays lit (at DIM_LEVEL PWM duty)
//   for HOLD_TICKS timebase ticks, then decays one LED per DECAY_TICKS ticks.
//
// Ports
//   clk         system clock
//   reset_n     synchronous active-low reset
//   in_pattern  bar pattern from the PIO output port (WIDTH bits)
//   enable      1 = normal operation, 0 = clear peak and force LEDs off
//   led_out     registered LED drive, 1 = on
//   peak_level  current peak: 0 = none, 1..WIDTH = LED index + 1
module led_peak_hold #(
    parameter int unsigned WIDTH       = 18,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned HOLD_TICKS  = 500,
    parameter int unsigned DECAY_TICKS = 50,
    parameter int unsigned PWM_BITS    = 4,
    parameter int unsigned DIM_LEVEL   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_pattern,
    input  logic             enable,
    output logic [WIDTH-1:0] led_out,
    output logic [4:0]       peak_level
);

    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned T_MAX = (HOLD_TICKS > DECAY_TICKS) ? HOLD_TICKS : DECAY_TICKS;
    localparam int unsigned TC_W  = $clog2(T_MAX + 1);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [TC_W-1:0] HOLD_LD  = TC_W'(HOLD_TICKS);
    localparam logic [TC_W-1:0] DECAY_LD = TC_W'(DECAY_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_DECAY
    } state_t;

    state_t             state, state_d;
    logic [4:0]         peak, peak_d;
    logic [TC_W-1:0]    tcnt, tcnt_d;

    logic [WIDTH-1:0]   pat_q;
    logic [PS_W-1:0]    ps_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic               tick;
    logic               dim_on;
    logic [4:0]         lvl;
    logic [WIDTH-1:0]   marker;

    // Stage 1 and free-running counters; enable does not stop these.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pat_q   <= '0;
            ps_cnt  <= '0;
            pwm_cnt <= '0;
        end else begin
            pat_q   <= in_pattern;
            ps_cnt  <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign tick   = (ps_cnt == PS_LAST);
    assign dim_on = (32'(pwm_cnt) < DIM_LEVEL);

    // Level = position of the highest set bit + 1; lower bits are ignored.
    always_comb begin
        lvl = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pat_q[i]) begin
                lvl = 5'(i + 1);
            end
        end
    end

    // Marker is a single bit at index peak-1, gated by the PWM duty.
    always_comb begin
        marker = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            marker[i] = dim_on && (peak == 5'(i + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            peak  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_d;
            peak  <= peak_d;
            tcnt  <= tcnt_d;
        end
    end

    // A new or equal level always wins over a tick in the same cycle.
    always_comb begin
        state_d = state;
        peak_d  = peak;
        tcnt_d  = tcnt;
        if (!enable) begin
            state_d = S_IDLE;
            peak_d  = '0;
            tcnt_d  = '0;
        end else if ((lvl != '0) && (lvl >= peak)) begin
            state_d = S_HOLD;
            peak_d  = lvl;
            tcnt_d  = HOLD_LD;
        end else if (tick) begin
            case (state)
                S_HOLD: begin
                    if (tcnt <= TC_W'(1)) begin
                        tcnt_d  = DECAY_LD;
                        state_d = S_DECAY;
                    end else begin
                        tcnt_d = tcnt - 1'b1;
                    end
                end
                S_DECAY: begin
                    if (tcnt <= TC_W'(1)) begin
                        peak_d = peak - 5'd1;
                        tcnt_d = DECAY_LD;
                        if (peak == 5'd1) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stage 2: a marker bit that is also set in pat_q simply stays fully on.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            led_out <= '0;
        end else begin
            led_out <= pat_q | marker;
        end
    end

    assign peak_level = peak;

endmodule

// File: tb/tb_led_peak_hold.sv
module tb_led_peak_hold;

    localparam int W  = 18;
    localparam int P  = 4;
    localparam int H  = 3;
    localparam int D  = 2;
    localparam int PB = 2;
    localparam int DL = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  in_pattern;
    logic          enable;
    logic [W-1:0]  led_out;
    logic [4:0]    peak_level;

    always #5 clk = ~clk;

    led_peak_hold #(
        .WIDTH(W),
        .PRESCALE(P),
        .HOLD_TICKS(H),
        .DECAY_TICKS(D),
        .PWM_BITS(PB),
        .DIM_LEVEL(DL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_pattern(in_pattern),
        .enable(enable),
        .led_out(led_out),
        .peak_level(peak_level)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: peak is derived from the captured level and the number
    // of ticks elapsed since capture, rather than from a state/timer pair.
    logic [W-1:0] m_pat;
    int           m_ps, m_pwm, m_cap, m_t, m_peak;
    logic [W-1:0] m_led;

    function automatic int mpeak();
        int d;
        if (m_cap == 0) return 0;
        if (m_t < H) return m_cap;
        d = (m_t - H) / D;
        return (m_cap > d) ? m_cap - d : 0;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic model_edge();
        int lvl, cur;
        logic [W-1:0] mark;
        if (!reset_n) begin
            m_pat = '0; m_ps = 0; m_pwm = 0; m_cap = 0; m_t = 0; m_led = '0;
        end else begin
            lvl = 0;
            for (int i = 0; i < W; i++) if (m_pat[i]) lvl = i + 1;
            cur  = mpeak();
            mark = '0;
            if (cur != 0 && m_pwm < DL) mark[cur-1] = 1'b1;
            if (!enable) begin
                m_led = '0; m_cap = 0; m_t = 0;
            end else begin
                m_led = m_pat | mark;
                if (lvl != 0 && lvl >= cur) begin
                    m_cap = lvl; m_t = 0;
                end else if (m_ps == P - 1 && cur != 0) begin
                    m_t++;
                end
            end
            m_pat = in_pattern;
            m_ps  = (m_ps + 1) % P;
            m_pwm = (m_pwm + 1) % (1 << PB);
        end
        m_peak = mpeak();
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("led_out", led_out, m_led);
        check("peak_level", peak_level, m_peak);
    endtask

    task automatic run_until(input int target, input int bound, output int n);
        n = 0;
        while (peak_level !== 5'(target) && n < bound) begin
            step();
            n++;
        end
        check("wait_peak", peak_level, target);
    endtask

    typedef struct {
        logic         rst_n;
        logic         en;
        logic [W-1:0] pat;
        logic [W-1:0] exp_led;
        logic [4:0]   exp_peak;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, on7, prev, last_change;

        vecs[0] = '{1'b0, 1'b1, 18'h3FFFF, 18'h00000, 5'd0};
        vecs[1] = '{1'b0, 1'b1, 18'h3FFFF, 18'h00000, 5'd0};
        vecs[2] = '{1'b1, 1'b1, 18'h3FFFF, 18'h00000, 5'd0};
        vecs[3] = '{1'b1, 1'b1, 18'h00000, 18'h3FFFF, 5'd18};
        vecs[4] = '{1'b1, 1'b1, 18'h00000, 18'h00000, 5'd18};
        vecs[5] = '{1'b1, 1'b1, 18'h00000, 18'h00000, 5'd18};
        vecs[6] = '{1'b1, 1'b1, 18'h00000, 18'h20000, 5'd18};

        reset_n = 1'b0; enable = 1'b1; in_pattern = '0;
        m_pat = '0; m_ps = 0; m_pwm = 0; m_cap = 0; m_t = 0; m_peak = 0; m_led = '0;

        // Reset and first capture, fixed vectors.
        foreach (vecs[i]) begin
            reset_n    = vecs[i].rst_n;
            enable     = vecs[i].en;
            in_pattern = vecs[i].pat;
            step();
            check("vec_led", led_out, vecs[i].exp_led);
            check("vec_peak", peak_level, vecs[i].exp_peak);
        end

        // Capture 0xFF, hold, decay.
        in_pattern = '0;
        run_until(0, 300, n);
        in_pattern = 18'h000FF; step();
        in_pattern = '0;        step();
        check("cap_peak", peak_level, 8);
        n = 0; on7 = 0;
        while (peak_level == 5'd8 && n < 40) begin
            step();
            n++;
            if (n <= 8 && led_out[7]) on7++;
        end
        check("marker_duty", on7, 2);
        check("first_decay", peak_level, 7);
        check_range("hold_plus_decay_clks", n, (H - 1) * P + 1 + D * P, H * P + D * P);
        run_until(0, 80, n);
        check("decay_to_idle_clks", n, 7 * D * P);

        // Gapped pattern: only the top bit matters for the level.
        in_pattern = 18'h20001;
        step(); step();
        for (int i = 0; i < 12; i++) begin
            step();
            check("gap_peak", peak_level, 18);
            check("gap_bit17", led_out[17], 1);
        end

        // Re-hit during DECAY at peak 5.
        in_pattern = '0;
        run_until(0, 300, n);
        in_pattern = 18'h0003F; step();
        in_pattern = '0;        step();
        run_until(5, 40, n);
        in_pattern = 18'h00010; step();
        in_pattern = '0;        step();
        check("rehit_peak", peak_level, 5);
        run_until(4, 40, n);
        check_range("rehit_hold_clks", n, (H - 1) * P + 1 + D * P, H * P + D * P);

        // Level 9 arriving on a tick edge: tick must not count.
        n = 0;
        while (m_ps != 2 && n < 8) begin step(); n++; end
        check("tick_align", m_ps, 2);
        in_pattern = 18'h00100; step();
        in_pattern = '0;        step();
        check("tick_cap_peak", peak_level, 9);
        run_until(8, 40, n);
        check("tick_cap_clks", n, H * P + D * P);

        // Enable deasserted mid-hold.
        in_pattern = 18'h00800; step();
        in_pattern = '0;        step(); step(); step();
        check("en_pre_peak", peak_level, 12);
        enable = 1'b0; step();
        check("en_off_led", led_out, 0);
        check("en_off_peak", peak_level, 0);
        enable = 1'b1; in_pattern = 18'h00007; step();
        in_pattern = '0; step();
        check("en_on_peak", peak_level, 3);

        // 64 clocks: decrements spaced exactly DECAY_TICKS*PRESCALE apart.
        prev = peak_level; last_change = -1;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (peak_level != 5'(prev)) begin
                if (last_change >= 0) check("decay_interval", i - last_change, D * P);
                last_change = i;
                prev = peak_level;
            end
        end
        check("wrap_end_peak", peak_level, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int k;
            logic [W-1:0] p;
            reset_n = ($urandom_range(0, 199) != 0);
            enable  = ($urandom_range(0, 99) != 0);
            p = '0;
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(0, W);
                for (int b = 0; b < W; b++)
                    if (b < k - 1) p[b] = 1'($urandom_range(0, 1));
                if (k != 0) p[k-1] = 1'b1;
            end
            in_pattern = p;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_peak_hold.md
# led_peak_hold

Downstream stage of the LED PIO in the Nios audiovisualizer: consumes the 18-bit bar pattern written by software and drives the physical LEDs. Adds a peak-hold marker: the highest level reached stays lit at reduced PWM brightness for a hold time, then decays one LED at a time. Software therefore writes only the instantaneous level, and the peak dynamics run in hardware.

## Interface
- WIDTH, 18, number of LEDs (pattern width), 1..31
- PRESCALE, 50000, clocks per timebase tick (1 ms at 50 MHz), ≥2
- HOLD_TICKS, 500, ticks the peak is held before decay starts, ≥1
- DECAY_TICKS, 50, ticks per one-LED decay step, ≥1
- PWM_BITS, 4, width of free-running PWM counter
- DIM_LEVEL, 4, peak-marker duty in PWM counts; 0 = marker off; ≥2^PWM_BITS = fully on
- clk  in  1  system clock
- reset_n  in  1  reset: one clock; reset is synchronous and active-low
- in_pattern  in  WIDTH  bar pattern from the PIO output port
- enable  in  1  1 = normal operation; 0 = clear peak, force outputs off
- led_out  out  WIDTH  LED drive, 1 = on
- peak_level  out  5  current peak level, 0 = none, 1..WIDTH = LED index+1

## Operation
- Stage 1: in_pattern is registered into pat_q every clock.
- Level: lvl = index of highest set bit of pat_q + 1. Set bits below the highest do not affect lvl. lvl = 0 when pat_q = 0.
- Timebase: prescale counter runs 0..PRESCALE-1 and wraps. tick is a 1-cycle pulse when count = PRESCALE-1. It runs freely and is cleared only by reset.
- PWM: pwm_cnt is PWM_BITS wide, increments every clock, and wraps. dim_on = (pwm_cnt < DIM_LEVEL).
- State machine: IDLE, HOLD, DECAY. Registers: peak (5 bits) and tcnt (timer in ticks).
  - Any state, lvl ≥ peak and lvl ≠ 0: peak ← lvl, tcnt ← HOLD_TICKS, state ← HOLD. This has priority over tick handling in the same cycle.
  - HOLD, on tick: tcnt decrements. When tcnt reaches 0, tcnt ← DECAY_TICKS and state ← DECAY.
  - DECAY, on tick: tcnt decrements. When tcnt reaches 0, peak ← peak-1 and tcnt ← DECAY_TICKS. If the new peak = 0, state ← IDLE.
  - IDLE: peak = 0. Leaves IDLE only on lvl ≥ 1.
- Stage 2 output: led_out ← pat_q | marker. marker has only bit (peak-1) set when peak ≠ 0 and dim_on. A marker bit that is also set in pat_q stays fully on.
- enable = 0: synchronously sets state ← IDLE, peak ← 0, tcnt ← 0, led_out ← 0. Stage 1 and the counters keep running.
- peak_level = peak register, driven directly.

## Timing
- Reset (reset_n = 0 at a clk edge) clears pat_q, led_out, peak, peak_level, tcnt, prescale, and pwm_cnt to 0, and sets state to IDLE.
- Latency from in_pattern to led_out is 2 clocks. From in_pattern to peak_level it is 2 clocks.
- The hold duration is HOLD_TICKS ticks counted from the first tick after capture. The capture-to-tick phase is whatever the free-running prescaler gives, so the hold spans (HOLD_TICKS-1)·PRESCALE+1 .. HOLD_TICKS·PRESCALE clocks.
- After the hold ends, each further decrement follows DECAY_TICKS ticks later.
- Level equal to the current peak (re-hit) reloads the hold timer, from either HOLD or DECAY.
- Reset or enable deassertion mid-hold or mid-decay takes effect on the next edge. There is no partial state.

## Test plan
Bench parameters: WIDTH=18, PRESCALE=4, HOLD_TICKS=3, DECAY_TICKS=2, PWM_BITS=2, DIM_LEVEL=1.
- Reset: hold reset_n=0 for 2 clocks with in_pattern=0x3FFFF. Required: led_out=0 and peak_level=0 throughout, led_out=0x3FFFF 2 clocks after release.
- Capture and hold: in_pattern=0x000FF for 1 clock, then 0. Required: peak_level=8; bit 7 of led_out high exactly when pwm_cnt=0 (1 of 4 clocks); decay to 7 after 3 ticks plus 2 ticks; IDLE reached after 8 decay steps.
- Gapped pattern: in_pattern=0x20001. Required: peak_level=18 and led_out[17]=1 continuously.
- Re-hit: during DECAY at peak 5, apply a pattern with level 5. Required: state returns to HOLD and tcnt reloads to 3. Apply level 9 in the same cycle as a tick. Required: peak=9 and the tick is ignored.
- enable: deassert mid-HOLD. Required: next edge gives led_out=0, peak_level=0, state IDLE. Reassert with in_pattern=0x7. Required: peak_level=3 two clocks later.
- Wrap: run 64 clocks. Required: tick every 4 clocks, pwm_cnt wraps 3→0, no drift.
